// File: rtl/mips_ctrl_pkg.sv
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared encodings for the multicycle MIPS32 main control:
//               opcodes, FSM states, ALUop, ALU B-source and PC-source
//               selects, and the packed control-output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_ctrl_pkg;

    // Opcodes recognised by the main control (instr[31:26])
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_j     = 6'b000010;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    // ALUop handed to the ALU control decoder
    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] c_srcb_b       = 2'b00;
    localparam logic [1:0] c_srcb_four    = 2'b01;
    localparam logic [1:0] c_srcb_imm     = 2'b10;
    localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

    // PC source select
    localparam logic [1:0] c_pcsrc_alu    = 2'b00;
    localparam logic [1:0] c_pcsrc_aluout = 2'b01;
    localparam logic [1:0] c_pcsrc_jump   = 2'b10;

    // Main FSM states; the numeric values are visible on state_dbg
    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_R_EXEC    = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_JUMP      = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_TRAP      = 4'd12
    } state_t;

    // All control outputs as one bundle so reset gating is a single mux
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    // True for any opcode this control knows how to sequence
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == c_op_rtype) || (op == c_op_lw)  || (op == c_op_sw) ||
               (op == c_op_beq)   || (op == c_op_j)   || (op == c_op_addi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
// ============================================================================
// Module      : mips_ctrl_decode
// Description : Purely combinational control-output decode from the current
//               FSM state, mem_ready and opcode.
//               Optional feature macro: ILLEGAL_TRAP_EN (TRAP state outputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    // Per-state control decode; everything not named for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = c_srcb_four;
                ctrl.alu_op    = c_aluop_add;
                ctrl.pc_source = c_pcsrc_alu;
                // IR and PC only update on the cycle the fetch completes
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = c_srcb_imm_sl2;
                ctrl.alu_op    = c_aluop_add;
`ifndef ILLEGAL_TRAP_EN
                // Unknown opcodes retire here as a NOP
                ctrl.instr_done = !is_known_op(opcode);
`endif
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = c_srcb_imm;
                ctrl.alu_op    = c_aluop_add;
            end
            ST_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            ST_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = c_srcb_b;
                ctrl.alu_op    = c_aluop_funct;
            end
            ST_R_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = c_srcb_b;
                ctrl.alu_op        = c_aluop_sub;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = c_pcsrc_aluout;
                ctrl.instr_done    = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = c_pcsrc_jump;
                ctrl.instr_done = 1'b1;
            end
            ST_ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = c_srcb_imm;
                ctrl.alu_op    = c_aluop_add;
            end
            ST_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP: begin
                ctrl.illegal_op = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mips_multicycle_control.sv
// ============================================================================
// Module      : mips_multicycle_control
// Description : Main control FSM for the multicycle MIPS32 datapath. Holds
//               the state register and next-state logic; output decode lives
//               in mips_ctrl_decode. All outputs forced to 0 while rst is high.
//               Optional feature macro: ILLEGAL_TRAP_EN (unknown opcode traps).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mem_to_reg,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_source,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    // State register; reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; memory-wait states hold until mem_ready
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH:     w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    c_op_lw, c_op_sw: w_next = ST_MEM_ADDR;
                    c_op_rtype:       w_next = ST_R_EXEC;
                    c_op_beq:         w_next = ST_BRANCH;
                    c_op_j:           w_next = ST_JUMP;
                    c_op_addi:        w_next = ST_ADDI_EXEC;
`ifdef ILLEGAL_TRAP_EN
                    default:          w_next = ST_TRAP;
`else
                    default:          w_next = ST_FETCH;
`endif
                endcase
            end
            ST_MEM_ADDR:  w_next = (opcode == c_op_sw) ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  w_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    w_next = ST_FETCH;
            ST_MEM_WRITE: w_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_R_EXEC:    w_next = ST_R_WB;
            ST_R_WB:      w_next = ST_FETCH;
            ST_BRANCH:    w_next = ST_FETCH;
            ST_JUMP:      w_next = ST_FETCH;
            ST_ADDI_EXEC: w_next = ST_ADDI_WB;
            ST_ADDI_WB:   w_next = ST_FETCH;
`ifdef ILLEGAL_TRAP_EN
            ST_TRAP:      w_next = ST_TRAP;
`endif
            default:      w_next = ST_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state     (r_state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (w_dec)
    );

    // Reset masks every output, including the state view
    assign w_ctrl = rst ? '0 : w_dec;

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign i_or_d        = w_ctrl.i_or_d;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_dst       = w_ctrl.reg_dst;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign instr_done    = w_ctrl.instr_done;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op    = w_ctrl.illegal_op;
`else
    assign illegal_op    = 1'b0;
`endif
    assign state_dbg     = rst ? '0 : STATE_W'(r_state);

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
// ============================================================================
// Module      : tb_mips_multicycle_control
// Description : Self-checking bench for mips_multicycle_control. Each driven
//               cycle pushes the expected state and control vector into a
//               scoreboard; the DUT outputs are popped and compared mid-cycle.
//               Honours ILLEGAL_TRAP_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_control;

    localparam logic [5:0] c_rt   = 6'b000000;
    localparam logic [5:0] c_lw   = 6'b100011;
    localparam logic [5:0] c_sw   = 6'b101011;
    localparam logic [5:0] c_beq  = 6'b000100;
    localparam logic [5:0] c_j    = 6'b000010;
    localparam logic [5:0] c_addi = 6'b001000;
    localparam logic [5:0] c_bad  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b1;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state_dbg;

    int          n_total = 0;
    int          n_pass  = 0;

    logic [3:0]  sb_state[$];
    logic [17:0] sb_ctrl[$];

    always #5 clk = ~clk;

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .instr_done    (instr_done),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    // Compare one observed value with its expectation and tally the outcome
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic bit known(input logic [5:0] op);
        return op == c_rt || op == c_lw || op == c_sw || op == c_beq ||
               op == c_j  || op == c_addi;
    endfunction

    // Reference control vector straight from the per-state output table
    function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic mr,
                                             input logic [5:0] op, input logic r);
        logic pcw = 0, pcc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0;
        logic m2r = 0, rd = 0, rw = 0, sa = 0, done = 0, ill = 0;
        logic [1:0] sb = 0, aop = 0, ps = 0;
        if (!r) begin
            case (st)
                4'd0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
                4'd1:  begin sb = 2'b11;
`ifndef ILLEGAL_TRAP_EN
                           done = !known(op);
`endif
                       end
                4'd2:  begin sa = 1; sb = 2'b10; end
                4'd3:  begin mrd = 1; iod = 1; end
                4'd4:  begin rw = 1; m2r = 1; done = 1; end
                4'd5:  begin mwr = 1; iod = 1; done = mr; end
                4'd6:  begin sa = 1; aop = 2'b10; end
                4'd7:  begin rw = 1; rd = 1; done = 1; end
                4'd8:  begin sa = 1; aop = 2'b01; pcc = 1; ps = 2'b01; done = 1; end
                4'd9:  begin pcw = 1; ps = 2'b10; done = 1; end
                4'd10: begin sa = 1; sb = 2'b10; end
                4'd11: begin rw = 1; done = 1; end
                4'd12: ill = 1;
                default: ;
            endcase
        end
        return {pcw, pcc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, aop, ps, done, ill};
    endfunction

    // One clock cycle: drive inputs, record the expectation, then compare
    task automatic cyc(input logic r, input logic [5:0] op, input logic mr, input logic [3:0] st);
        logic [17:0] act;
        @(negedge clk);
        rst = r; opcode = op; mem_ready = mr;
        sb_state.push_back(r ? 4'd0 : st);
        sb_ctrl.push_back(exp_ctrl(st, mr, op, r));
        #2;
        act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, instr_done, illegal_op};
        check($sformatf("state(op=%b,exp_st=%0d)", op, st), 32'(state_dbg), 32'(sb_state.pop_front()));
        check($sformatf("ctrl(op=%b,st=%0d)", op, st), 32'(act), 32'(sb_ctrl.pop_front()));
    endtask

    initial begin
        // Reset held for two cycles, outputs all 0
        cyc(1, c_rt, 1, 0);
        cyc(1, c_rt, 1, 0);

        // R-type add
        cyc(0, c_rt, 1, 0);  cyc(0, c_rt, 1, 1);  cyc(0, c_rt, 1, 6);  cyc(0, c_rt, 1, 7);

        // lw with three wait cycles in MEM_READ
        cyc(0, c_lw, 1, 0);  cyc(0, c_lw, 1, 1);  cyc(0, c_lw, 1, 2);
        for (int i = 0; i < 3; i++) cyc(0, c_lw, 0, 3);
        cyc(0, c_lw, 1, 3);  cyc(0, c_lw, 1, 4);

        // sw with a two-cycle FETCH stall and a one-cycle write stall
        cyc(0, c_sw, 0, 0);  cyc(0, c_sw, 0, 0);  cyc(0, c_sw, 1, 0);
        cyc(0, c_sw, 0, 1);  cyc(0, c_sw, 0, 2);  cyc(0, c_sw, 0, 5);  cyc(0, c_sw, 1, 5);

        // addi, beq, j
        cyc(0, c_addi, 1, 0); cyc(0, c_addi, 1, 1); cyc(0, c_addi, 1, 10); cyc(0, c_addi, 0, 11);
        cyc(0, c_beq, 1, 0);  cyc(0, c_beq, 1, 1);  cyc(0, c_beq, 0, 8);
        cyc(0, c_j, 1, 0);    cyc(0, c_j, 1, 1);    cyc(0, c_j, 1, 9);

        // Reset in the middle of an R-type abandons it
        cyc(0, c_rt, 1, 0);  cyc(0, c_rt, 1, 1);  cyc(1, c_rt, 1, 6);
        cyc(0, c_rt, 1, 0);  cyc(0, c_rt, 1, 1);  cyc(0, c_rt, 1, 6);  cyc(0, c_rt, 1, 7);

        // Illegal opcode
        cyc(0, c_bad, 1, 0); cyc(0, c_bad, 1, 1);
`ifdef ILLEGAL_TRAP_EN
        cyc(0, c_bad, 1, 12); cyc(0, c_rt, 0, 12); cyc(0, c_rt, 1, 12);
        cyc(1, c_rt, 1, 0);
`endif
        cyc(0, c_rt, 1, 0);  cyc(0, c_rt, 1, 1);  cyc(0, c_rt, 1, 6);  cyc(0, c_rt, 1, 7);
        cyc(0, c_rt, 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
